bus_responder: RTL and testbench

BUS_RESPONDER -- requirements
Module: bus_responder

---
 rtl/bus_responder_if.sv | 24 ++
 rtl/bus_responder.sv | 93 +++++++++
 tb/tb_bus_responder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/bus_responder_if.sv
// Multiplexed-address bus between a bus master and bus_responder.
// The master drives the beat signals; the responder drives the response signals.
interface bus_responder_if;
  logic        phi;
  logic        bus_valid;
  logic [7:0]  addr_mux;
  logic        rw;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        resp_hit;
  logic [7:0]  miss_count;
  logic [15:0] addr_full;

  modport master (
    output phi, bus_valid, addr_mux, rw, data_in,
    input  data_out, data_oe, resp_hit, miss_count, addr_full
  );

  modport slave (
    input  phi, bus_valid, addr_mux, rw, data_in,
    output data_out, data_oe, resp_hit, miss_count, addr_full
  );
endinterface

// File: rtl/bus_responder.sv
// Bus responder for a multiplexed-address bus: a high-address beat (phi=1) followed by a
// low-address beat (phi=0) completes a transaction. Addresses {BASE_HI, 000xxxxx} hit a
// 32 x 8 storage array; everything else counts as a miss.
// Build option: define BUS_RESPONDER_WRITE_EN to let write hits update storage; without
// it storage is read-only after reset (write hits still pulse resp_hit).
module bus_responder #(
  parameter logic [7:0] BASE_HI = 8'h00
) (
  input logic           clk_output,
  input logic           rst_n,
  bus_responder_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StGotHi, StResp} state_e;

  state_e     state;
  logic [7:0] abh;
  logic [7:0] mem [32];
  logic       hit;

`ifndef BUS_RESPONDER_WRITE_EN
  // Write data has no destination in the read-only build.
  logic unused_data_in;
  assign unused_data_in = ^bus.data_in;
`endif

  // Window decode uses the latched high byte and the low byte currently on the bus.
  assign hit = (abh == BASE_HI) && (bus.addr_mux[7:5] == 3'b000);

  // Beat sequencing, storage access and all registered outputs; reset wins over any beat.
  always_ff @(posedge clk_output) begin
    bus.resp_hit <= 1'b0;
    if (!rst_n) begin
      state          <= StIdle;
      abh            <= 8'h00;
      bus.data_out   <= 8'h00;
      bus.data_oe    <= 1'b0;
      bus.miss_count <= 8'h00;
      bus.addr_full  <= 16'h0000;
      for (int i = 0; i < 32; i++) begin
        mem[i] <= 8'(i);
      end
    end else begin
      unique case (state)
        StIdle: begin
          // Stray low beats are ignored here.
          if (bus.bus_valid && bus.phi) begin
            abh   <= bus.addr_mux;
            state <= StGotHi;
          end
        end
        StGotHi: begin
          if (bus.bus_valid) begin
            if (bus.phi) begin
              abh <= bus.addr_mux;
            end else begin
              bus.addr_full <= {abh, bus.addr_mux};
              state         <= StResp;
              if (hit) begin
                bus.resp_hit <= 1'b1;
                if (!bus.rw) begin
                  bus.data_out <= mem[bus.addr_mux[4:0]];
                  bus.data_oe  <= 1'b1;
                end else begin
                  bus.data_oe <= 1'b0;
`ifdef BUS_RESPONDER_WRITE_EN
                  mem[bus.addr_mux[4:0]] <= bus.data_in;
`endif
                end
              end else begin
                // Miss: data_out keeps its last value.
                bus.data_oe <= 1'b0;
                if (bus.miss_count != 8'hFF) begin
                  bus.miss_count <= bus.miss_count + 8'h01;
                end
              end
            end
          end
        end
        StResp: begin
          // Only a new high beat leaves the response phase; outputs otherwise hold.
          if (bus.bus_valid && bus.phi) begin
            abh         <= bus.addr_mux;
            bus.data_oe <= 1'b0;
            state       <= StGotHi;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: a table of transactions with hand-computed
// responses queued as a scoreboard, plus hand-written multi-cycle corner sequences.
module tb_bus_responder;

  logic clk_output = 1'b0;
  logic rst_n      = 1'b0;

  bus_responder_if bus ();

  bus_responder #(.BASE_HI(8'h00)) dut (
    .clk_output (clk_output),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  always #5 clk_output = ~clk_output;

  int checks = 0;
  int errors = 0;

`ifdef BUS_RESPONDER_WRITE_EN
  localparam logic [7:0] Rd03 = 8'hA5;
  localparam logic [7:0] Rd1F = 8'h5A;
`else
  localparam logic [7:0] Rd03 = 8'h03;
  localparam logic [7:0] Rd1F = 8'h1F;
`endif

  typedef struct {
    logic [7:0]  data_out;
    logic        data_oe;
    logic        resp_hit;
    logic [7:0]  miss_count;
    logic [15:0] addr_full;
  } exp_t;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       rw;
    logic [7:0] wd;
    exp_t       exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic beat(input logic p, input logic [7:0] a, input logic r, input logic [7:0] d);
    @(negedge clk_output);
    bus.bus_valid = 1'b1;
    bus.phi       = p;
    bus.addr_mux  = a;
    bus.rw        = r;
    bus.data_in   = d;
  endtask

  // Ends at the negedge after the response edge with the bus idle.
  task automatic idle();
    @(negedge clk_output);
    bus.bus_valid = 1'b0;
  endtask

  task automatic txn(input logic [7:0] hi, input logic [7:0] lo, input logic r,
                     input logic [7:0] d);
    beat(1'b1, hi, 1'b0, 8'h00);
    beat(1'b0, lo, r, d);
    idle();
  endtask

  task automatic do_reset();
    @(negedge clk_output);
    rst_n         = 1'b0;
    bus.bus_valid = 1'b0;
    repeat (2) @(negedge clk_output);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_data_out"}, 16'(bus.data_out), 16'h00);
    check({tag, "_data_oe"}, 16'(bus.data_oe), 16'h0);
    check({tag, "_resp_hit"}, 16'(bus.resp_hit), 16'h0);
    check({tag, "_miss_count"}, 16'(bus.miss_count), 16'h00);
    check({tag, "_addr_full"}, bus.addr_full, 16'h0000);
  endtask

  initial begin
    exp_t e;
    bus.phi = 1'b0; bus.bus_valid = 1'b0; bus.addr_mux = 8'h00;
    bus.rw = 1'b0; bus.data_in = 8'h00;

    //                 hi     lo     rw    wd       data_out oe    hit   miss   addr
    vecs[0] = '{8'h00, 8'h05, 1'b0, 8'h00, '{8'h05, 1'b1, 1'b1, 8'd0, 16'h0005}};
    vecs[1] = '{8'h00, 8'h03, 1'b1, 8'hA5, '{8'h05, 1'b0, 1'b1, 8'd0, 16'h0003}};
    vecs[2] = '{8'h00, 8'h03, 1'b0, 8'h00, '{Rd03,  1'b1, 1'b1, 8'd0, 16'h0003}};
    vecs[3] = '{8'h12, 8'h03, 1'b0, 8'h00, '{Rd03,  1'b0, 1'b0, 8'd1, 16'h1203}};
    vecs[4] = '{8'h00, 8'h25, 1'b0, 8'h00, '{Rd03,  1'b0, 1'b0, 8'd2, 16'h0025}};
    vecs[5] = '{8'h00, 8'h1F, 1'b0, 8'h00, '{8'h1F, 1'b1, 1'b1, 8'd2, 16'h001F}};
    vecs[6] = '{8'h01, 8'h1F, 1'b1, 8'h77, '{8'h1F, 1'b0, 1'b0, 8'd3, 16'h011F}};
    vecs[7] = '{8'h00, 8'h1F, 1'b1, 8'h5A, '{8'h1F, 1'b0, 1'b1, 8'd3, 16'h001F}};
    vecs[8] = '{8'h00, 8'h1F, 1'b0, 8'h00, '{Rd1F,  1'b1, 1'b1, 8'd3, 16'h001F}};
    vecs[9] = '{8'hFF, 8'h00, 1'b0, 8'h00, '{Rd1F,  1'b0, 1'b0, 8'd4, 16'hFF00}};

    do_reset();
    check_reset_state("reset");

    // Table-driven transactions through the scoreboard.
    for (int i = 0; i < 10; i++) begin
      sb.push_back(vecs[i].exp);
      txn(vecs[i].hi, vecs[i].lo, vecs[i].rw, vecs[i].wd);
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL vec%0d_scoreboard: got empty queue, expected an entry", i);
      end else begin
        e = sb.pop_front();
        check($sformatf("vec%0d_data_out", i), 16'(bus.data_out), 16'(e.data_out));
        check($sformatf("vec%0d_data_oe", i), 16'(bus.data_oe), 16'(e.data_oe));
        check($sformatf("vec%0d_resp_hit", i), 16'(bus.resp_hit), 16'(e.resp_hit));
        check($sformatf("vec%0d_miss_count", i), 16'(bus.miss_count), 16'(e.miss_count));
        check($sformatf("vec%0d_addr_full", i), bus.addr_full, e.addr_full);
      end
      @(negedge clk_output);
      check($sformatf("vec%0d_hit_pulse_end", i), 16'(bus.resp_hit), 16'h0);
    end

    // Stray low beat in IDLE, re-latched high beat, then RESP hold and re-entry.
    do_reset();
    beat(1'b0, 8'h09, 1'b0, 8'h00);
    idle();
    check("stray_addr_full", bus.addr_full, 16'h0000);
    check("stray_resp_hit", 16'(bus.resp_hit), 16'h0);
    check("stray_data_oe", 16'(bus.data_oe), 16'h0);
    beat(1'b1, 8'h7F, 1'b0, 8'h00);
    beat(1'b1, 8'h00, 1'b0, 8'h00);
    beat(1'b0, 8'h01, 1'b0, 8'h00);
    idle();
    check("relatch_addr_full", bus.addr_full, 16'h0001);
    check("relatch_data_out", 16'(bus.data_out), 16'h01);
    check("relatch_data_oe", 16'(bus.data_oe), 16'h1);
    check("relatch_resp_hit", 16'(bus.resp_hit), 16'h1);
    check("relatch_miss_count", 16'(bus.miss_count), 16'h00);
    beat(1'b0, 8'h1E, 1'b0, 8'h00);
    idle();
    check("resp_hold_data_oe", 16'(bus.data_oe), 16'h1);
    check("resp_hold_data_out", 16'(bus.data_out), 16'h01);
    check("resp_hold_addr_full", bus.addr_full, 16'h0001);
    check("resp_hold_resp_hit", 16'(bus.resp_hit), 16'h0);
    beat(1'b1, 8'h00, 1'b0, 8'h00);
    idle();
    check("resp_exit_data_oe", 16'(bus.data_oe), 16'h0);
    check("resp_exit_data_out", 16'(bus.data_out), 16'h01);
    beat(1'b0, 8'h02, 1'b0, 8'h00);
    idle();
    check("gothi_hold_data_out", 16'(bus.data_out), 16'h02);
    check("gothi_hold_addr_full", bus.addr_full, 16'h0002);

    // Reset during GOT_HI of a write abandons it.
    beat(1'b1, 8'h00, 1'b0, 8'h00);
    beat(1'b0, 8'h04, 1'b1, 8'h77);
    rst_n = 1'b0;
    @(negedge clk_output);
    bus.bus_valid = 1'b0;
    rst_n = 1'b1;
    check_reset_state("midreset");
    txn(8'h00, 8'h04, 1'b0, 8'h00);
    check("midreset_mem4", 16'(bus.data_out), 16'h04);
    check("midreset_read_oe", 16'(bus.data_oe), 16'h1);

    // Miss counting and saturation.
    do_reset();
    txn(8'h12, 8'h03, 1'b0, 8'h00);
    check("miss1_count", 16'(bus.miss_count), 16'h01);
    check("miss1_data_oe", 16'(bus.data_oe), 16'h0);
    check("miss1_resp_hit", 16'(bus.resp_hit), 16'h0);
    for (int n = 2; n <= 300; n++) begin
      txn(8'(n), 8'hE0, n[0], 8'h00);
      if (n == 254) check("miss254_count", 16'(bus.miss_count), 16'hFE);
      if (n == 256) check("miss256_count", 16'(bus.miss_count), 16'hFF);
    end
    check("miss300_count", 16'(bus.miss_count), 16'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
